// File: rtl/video_timing_ctrl.sv
// Programmable video timing generator: shadow/active timing registers, IDLE/RUN/STOPPING
// control, and registered DE/HS/VS aligned with the published h/v counters.
module video_timing_ctrl #(
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [10:0] cfg_data,
  output logic        cfg_err,
  output logic        hdmi_de,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic        sof,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t      state, state_n;
  logic [10:0] shadow   [8];
  logic [10:0] active   [8];
  logic [10:0] active_n [8];

  logic [11:0] htotal, vtotal;
  logic [11:0] h_n, v_n;
  logic        h_last, v_last, wrap;
  logic        copy, fc_inc, sof_n, busy_n;
  logic [11:0] hr_n, hsync_lo, hsync_hi, vr_n, vsync_lo, vsync_hi;
  logic        de_n, hs_n, vs_n;

  function automatic logic [10:0] def_val(input int unsigned idx);
    case (idx)
      0:       return 11'd1280;
      4:       return 11'd720;
      2:       return 11'd2;
      6:       return 11'd4;
      default: return 11'd8;
    endcase
  endfunction

  assign htotal = {1'b0, active[0]} + {1'b0, active[1]} + {1'b0, active[2]} + {1'b0, active[3]};
  assign vtotal = {1'b0, active[4]} + {1'b0, active[5]} + {1'b0, active[6]} + {1'b0, active[7]};
  assign h_last = (h_cnt == htotal - 12'd1);
  assign v_last = (v_cnt == vtotal - 12'd1);
  assign wrap   = h_last && v_last;

  always_comb begin
    state_n = state;
    h_n     = h_cnt;
    v_n     = v_cnt;
    copy    = 1'b0;
    fc_inc  = 1'b0;
    sof_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          h_n     = '0;
          v_n     = '0;
          copy    = 1'b1;
          sof_n   = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (h_last) begin
          h_n = '0;
          v_n = v_last ? '0 : v_cnt + 12'd1;
        end else begin
          h_n = h_cnt + 12'd1;
        end
        if (stop)
          state_n = STOPPING;
        else if (start)
          state_n = RUN;
        // A wrap while still stopping ends generation; any other wrap starts a new frame.
        if (wrap) begin
          copy   = 1'b1;
          fc_inc = 1'b1;
          if (state == STOPPING && state_n == STOPPING)
            state_n = IDLE;
          else
            sof_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
    if (!busy_n) begin
      h_n = '0;
      v_n = '0;
    end

    for (int unsigned i = 0; i < 8; i++)
      active_n[i] = copy ? shadow[i] : active[i];

    // Output decode looks ahead at next-cycle counters/registers so registered outputs line up.
    hr_n     = {1'b0, active_n[0]};
    hsync_lo = hr_n + {1'b0, active_n[1]};
    hsync_hi = hsync_lo + {1'b0, active_n[2]};
    vr_n     = {1'b0, active_n[4]};
    vsync_lo = vr_n + {1'b0, active_n[5]};
    vsync_hi = vsync_lo + {1'b0, active_n[6]};

    de_n = busy_n && (h_n < hr_n) && (v_n < vr_n);
    hs_n = (busy_n && h_n >= hsync_lo && h_n < hsync_hi) ? HS_POL : ~HS_POL;
    vs_n = (busy_n && v_n >= vsync_lo && v_n < vsync_hi) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
      hdmi_de   <= 1'b0;
      hdmi_hs   <= ~HS_POL;
      hdmi_vs   <= ~VS_POL;
      sof       <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow[i] <= def_val(i);
        active[i] <= def_val(i);
      end
    end else begin
      state   <= state_n;
      h_cnt   <= h_n;
      v_cnt   <= v_n;
      hdmi_de <= de_n;
      hdmi_hs <= hs_n;
      hdmi_vs <= vs_n;
      sof     <= sof_n;
      busy    <= busy_n;
      if (fc_inc)
        frame_cnt <= frame_cnt + 8'd1;
      for (int unsigned i = 0; i < 8; i++)
        active[i] <= active_n[i];
      cfg_err <= 1'b0;
      if (cfg_wr) begin
        if (!cfg_addr[0] && cfg_data == '0)
          cfg_err <= 1'b1;
        else
          shadow[cfg_addr] <= cfg_data;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a frame-position reference model predicts every output
// each cycle for directed scenarios and randomized start/stop/config traffic.
module tb_video_timing_ctrl;

  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b0;

  logic        hdmi_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cfg_wr = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [10:0] cfg_data = '0;
  logic        cfg_err, hdmi_de, hdmi_hs, hdmi_vs, sof, busy;
  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  frame_cnt;
  logic [37:0] obs;

  always #5 hdmi_clk = ~hdmi_clk;

  video_timing_ctrl #(.HS_POL(HSP), .VS_POL(VSP)) dut (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .hdmi_de(hdmi_de), .hdmi_hs(hdmi_hs), .hdmi_vs(hdmi_vs),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .sof(sof), .busy(busy), .frame_cnt(frame_cnt)
  );

  assign obs = {cfg_err, hdmi_de, hdmi_hs, hdmi_vs, sof, busy, frame_cnt, h_cnt, v_cnt};

  int tests = 0, fails = 0;

  // Model: mode 0 idle / 1 run / 2 stopping; pos is the linear pixel index within the frame.
  int mode, pos, fc;
  int sh[8];
  int ac[8];
  bit m_err, m_sof;

  function automatic int def_val(input int i);
    case (i)
      0: return 1280;
      4: return 720;
      2: return 2;
      6: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int ht();
    return (ac[0] + ac[1] + ac[2] + ac[3]) % 4096;
  endfunction

  function automatic int vt();
    return (ac[4] + ac[5] + ac[6] + ac[7]) % 4096;
  endfunction

  function automatic logic [37:0] exp_vec();
    int h, v;
    bit b, de;
    logic hs, vs;
    b  = (mode != 0);
    h  = b ? pos % ht() : 0;
    v  = b ? pos / ht() : 0;
    de = b && h < ac[0] && v < ac[4];
    hs = (b && h >= ac[0] + ac[1] && h < ac[0] + ac[1] + ac[2]) ? HSP : ~HSP;
    vs = (b && v >= ac[4] + ac[5] && v < ac[4] + ac[5] + ac[6]) ? VSP : ~VSP;
    return {m_err, de, hs, vs, m_sof, b, 8'(fc), 12'(h), 12'(v)};
  endfunction

  function automatic void model_reset();
    mode = 0; pos = 0; fc = 0; m_err = 0; m_sof = 0;
    for (int i = 0; i < 8; i++) begin
      sh[i] = def_val(i);
      ac[i] = def_val(i);
    end
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit wr, input int addr, input int data);
    int  old[8];
    int  nm;
    bit  last;
    old    = sh;
    last   = (mode != 0) && (pos == ht() * vt() - 1);
    m_err  = wr && (addr % 2 == 0) && data == 0;
    if (wr && !m_err) sh[addr] = data;
    m_sof = 0;
    if (mode == 0) begin
      if (st && !sp) begin
        mode = 1; pos = 0; ac = old; m_sof = 1;
      end
    end else begin
      nm = sp ? 2 : (st ? 1 : mode);
      if (last) begin
        ac  = old;
        fc  = (fc + 1) % 256;
        pos = 0;
        if (mode == 2 && nm == 2) nm = 0;
        else m_sof = 1;
      end else begin
        pos++;
      end
      mode = nm;
    end
  endfunction

  task automatic step(input bit st, input bit sp, input bit wr, input int addr, input int data);
    start = st; stop = sp; cfg_wr = wr;
    cfg_addr = 3'(addr); cfg_data = 11'(data);
    @(posedge hdmi_clk);
    model_step(st, sp, wr, addr, data);
    #1;
    start = 1'b0; stop = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_wr = 1'b0;
    repeat (n) begin
      @(posedge hdmi_clk);
      model_reset();
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    if (obs !== exp_vec()) begin fails++; $display("FAIL reset: got %h want %h", obs, exp_vec()); end
    tests++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
  endtask

  task automatic test_basic();
    int cfg[8];
    int de_count, sof_count, first_sof, second_sof;
    cfg = '{4, 1, 2, 1, 3, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, i, cfg[i]);
      if (obs !== exp_vec()) begin fails++; $display("FAIL basic_cfg %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
    de_count = 0; sof_count = 0; first_sof = -1; second_sof = -1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 96; i++) begin
      if (obs !== exp_vec()) begin fails++; $display("FAIL basic cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
      if (i < 48 && hdmi_de === 1'b1) de_count++;
      if (sof === 1'b1) begin
        sof_count++;
        if (first_sof < 0) first_sof = i; else if (second_sof < 0) second_sof = i;
      end
      step(0, 0, 0, 0, 0);
    end
    if (de_count !== 12) begin fails++; $display("FAIL basic_de_count: got %0d want 12", de_count); end
    tests++;
    if (second_sof - first_sof !== 48) begin fails++; $display("FAIL basic_sof_period: got %0d want 48", second_sof - first_sof); end
    tests++;
    if (sof_count !== 2) begin fails++; $display("FAIL basic_sof_count: got %0d want 2", sof_count); end
    tests++;
  endtask

  task automatic test_cfg_err();
    step(0, 0, 1, 2, 0);
    if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
    tests++;
    step(0, 0, 0, 0, 0);
    if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    tests++;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL cfg_err cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
  endtask

  task automatic test_midframe_cfg();
    int line_de;
    while (!(h_cnt == 12'd3 && v_cnt == 12'd1)) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 6);
    for (int i = 0; i < 140; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL midframe cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
    for (int t = 0; t < 80 && sof !== 1'b1; t++) step(0, 0, 0, 0, 0);
    line_de = 0;
    for (int i = 0; i < 10; i++) begin
      if (hdmi_de === 1'b1) line_de++;
      step(0, 0, 0, 0, 0);
    end
    if (line_de !== 6 || h_cnt !== 12'd0 || v_cnt !== 12'd1) begin
      fails++; $display("FAIL midframe_line: de %0d h %0d v %0d want 6 0 1", line_de, h_cnt, v_cnt);
    end
    tests++;
  endtask

  task automatic test_stop_start();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 90; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL resume cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL stop cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
    if (busy !== 1'b0) begin fails++; $display("FAIL stop_idle: busy %b want 0", busy); end
    tests++;
  endtask

  task automatic test_random();
    bit st, sp, wr;
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 40) == 0);
      sp = ($urandom_range(0, 60) == 0);
      wr = ($urandom_range(0, 5) == 0);
      step(st, sp, wr, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      if (obs !== exp_vec()) begin fails++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
  endtask

  task automatic test_reset_default();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    do_reset(1);
    if (obs !== exp_vec()) begin fails++; $display("FAIL reset_mid: got %h want %h", obs, exp_vec()); end
    tests++;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2700; i++) begin
      if (obs !== exp_vec()) begin fails++; $display("FAIL default cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_frame_wrap();
    int cfg[8];
    cfg = '{1, 0, 1, 0, 1, 0, 1, 0};
    do_reset(1);
    for (int i = 0; i < 8; i++) step(0, 0, 1, i, cfg[i]);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 1030; i++) begin
      step(0, 0, 0, 0, 0);
      if (obs !== exp_vec()) begin fails++; $display("FAIL frame_wrap cyc %0d: got %h want %h", i, obs, exp_vec()); end
      tests++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_cfg_err();
    test_midframe_cfg();
    test_stop_start();
    test_random();
    test_reset_default();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have parameter HS_POL, default 1'b0, hs output level during the sync pulse.
REQ-002 SHALL have parameter VS_POL, default 1'b0, vs output level during the sync pulse.
REQ-003 SHALL have port hdmi_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to begin frame generation.
REQ-006 SHALL have port stop  input  1  request to end generation after the current frame.
REQ-007 SHALL have port cfg_wr  input  1  config write strobe.
REQ-008 SHALL have port cfg_addr  input  3  register select: 0 hr, 1 hfp, 2 hs, 3 hbp, 4 vr, 5 vfp, 6 vs, 7 vbp.
REQ-009 SHALL have port cfg_data  input  11  config write value.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected write.
REQ-011 SHALL have port hdmi_de  output  1  active-pixel enable.
REQ-012 SHALL have port hdmi_hs  output  1  horizontal sync, level per HS_POL.
REQ-013 SHALL have port hdmi_vs  output  1  vertical sync, level per VS_POL.
REQ-014 SHALL have port h_cnt  output  12  pixel index within line.
REQ-015 SHALL have port v_cnt  output  12  line index within frame.
REQ-016 SHALL have port sof  output  1  one-cycle pulse when h_cnt=0 and v_cnt=0 while running.
REQ-017 SHALL have port busy  output  1  high in RUN and STOPPING.
REQ-018 SHALL have port frame_cnt  output  8  count of completed frames.

Function
REQ-019 SHALL keep shadow registers, written by cfg_wr, and active registers, used by the counters.
REQ-020 SHALL reject a cfg_wr of 0 to hr, hs, vr or vs: shadow unchanged, cfg_err pulses the next cycle; porches accept 0.
REQ-021 SHALL compute htotal=hr+hfp+hs+hbp and vtotal=vr+vfp+vs+vbp in 12 bits from the active registers.
REQ-022 SHALL order each line and frame as active, front porch, sync, back porch.
REQ-023 SHALL run the FSM states IDLE, RUN, STOPPING.
REQ-024 IDLE: start=1 and stop=0 copy shadow to active and set h_cnt=v_cnt=0 with sof=1 on the next cycle; state becomes RUN.
REQ-025 RUN: h_cnt increments each cycle; at htotal-1 it wraps to 0 and v_cnt increments; at v_cnt=vtotal-1 the wrap sets v_cnt=0.
REQ-026 SHALL, at every frame wrap, copy shadow to active (values seen that cycle), increment frame_cnt (255 wraps to 0), and pulse sof.
REQ-027 RUN: stop=1 moves the FSM to STOPPING; start is ignored in RUN.
REQ-028 STOPPING: start=1 returns the FSM to RUN; otherwise, at the frame wrap, go to IDLE, increment frame_cnt, no sof.
REQ-029 SHALL give stop priority when start and stop are both high, in every state.
REQ-030 SHALL drive hdmi_de=1 iff busy and h_cnt<hr and v_cnt<vr, aligned with the same-cycle counters.
REQ-031 SHALL assert hs when busy and hr+hfp<=h_cnt<hr+hfp+hs; otherwise ~HS_POL. vs uses the v terms and the same rule.
REQ-032 SHALL hold counters at 0, de=0 and syncs inactive in IDLE.
REQ-033 SHALL let a cfg_wr coinciding with a frame wrap affect the following frame only.

Reset
REQ-034 SHALL, on rst_n=0 at a clock edge, enter IDLE with h_cnt=v_cnt=0, frame_cnt=0, de/sof/busy/cfg_err=0 and syncs inactive.
REQ-035 SHALL load shadow and active to 1280/8/2/8 (h) and 720/8/4/8 (v) on reset, aborting any frame mid-operation.

Verification
REQ-036 Config h=4/1/2/1, v=3/1/1/1, start -> htotal 8, vtotal 6, 12 de cycles per 48-cycle frame, sof every 48 cycles.
REQ-037 Same config, HS_POL=0 -> hdmi_hs low exactly at h_cnt 5..6; hdmi_vs low for the whole of line 4.
REQ-038 Write hr=6 mid-frame -> current frame keeps 4 de cycles per line; next frame has 6 de cycles per line and htotal 10.
REQ-039 cfg_wr addr 2 data 0 -> cfg_err pulse one cycle later and hs width stays 2.
REQ-040 stop mid-frame, then start before the wrap -> busy stays 1 and sof follows; stop alone -> IDLE after the wrap with frame_cnt+1.
REQ-041 rst_n low mid-line, then start -> counters, frame_cnt and outputs cleared, then defaults give a 1298x740 frame.
